sobel_filter: RTL and testbench

SOBEL_FILTER -- requirements
Module: sobel_filter

---
 rtl/sobel_pkg.sv | 38 +++
 rtl/sobel_isqrt.sv | 60 ++++++
 rtl/sobel_filter.sv | 108 ++++++++++
 tb/tb_sobel_filter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared constants, mask tables and FSM encoding for the Sobel edge-magnitude filter.
package sobel_pkg;

  localparam int unsigned PIX_W  = 24;
  localparam int unsigned WIN    = 9;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ACC_W  = 12;
  localparam int unsigned SUM_W  = 21;
  localparam int unsigned ROOT_W = 11;
  localparam int unsigned RAD_W  = 2 * ROOT_W;

  // Window order p0..p8, row-major from the top-left pixel
  localparam logic signed [ACC_W-1:0] GX_MASK [WIN] = '{
    -12'sd1, 12'sd0, 12'sd1,
    -12'sd2, 12'sd0, 12'sd2,
    -12'sd1, 12'sd0, 12'sd1
  };
  localparam logic signed [ACC_W-1:0] GY_MASK [WIN] = '{
    -12'sd1, -12'sd2, -12'sd1,
     12'sd0,  12'sd0,  12'sd0,
     12'sd1,  12'sd2,  12'sd1
  };

  typedef enum logic [1:0] {
    ST_ACCUM,
    ST_CALC,
    ST_ROOT,
    ST_OUT
  } state_t;

  function automatic logic [7:0] gray_of(input logic [7:0] r, input logic [7:0] g,
                                         input logic [7:0] b);
    logic [9:0] s;
    s = 10'(r) + 10'(g) + 10'(b);
    return 8'(s / 10'd3);
  endfunction

endpackage

// File: rtl/sobel_isqrt.sv
// Restoring integer square root, one result bit per cycle over ROOT_W cycles.
module sobel_isqrt
  import sobel_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [RAD_W-1:0]  radicand,
  output logic [ROOT_W-1:0] root,
  output logic              done
);

  logic [RAD_W-1:0]  rad;
  logic [ROOT_W-1:0] rem;
  logic [CNT_W-1:0]  iter;
  logic              run;
  logic [ROOT_W+1:0] cand;
  logic [ROOT_W+1:0] trial;
  logic              fits;

  // The remainder never exceeds 2*root, so ROOT_W bits hold it until the final step
  always_comb begin
    cand  = {rem, rad[RAD_W-1 -: 2]};
    trial = {root, 2'b01};
    fits  = (cand >= trial);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rad  <= '0;
      rem  <= '0;
      root <= '0;
      iter <= '0;
      run  <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      rad  <= radicand;
      rem  <= '0;
      root <= '0;
      iter <= '0;
      run  <= 1'b1;
      done <= 1'b0;
    end else if (run) begin
      rad <= {rad[RAD_W-3:0], 2'b00};
      if (fits) begin
        rem  <= ROOT_W'(cand - trial);
        root <= {root[ROOT_W-2:0], 1'b1};
      end else begin
        rem  <= cand[ROOT_W-1:0];
        root <= {root[ROOT_W-2:0], 1'b0};
      end
      iter <= iter + 1'b1;
      if (iter == CNT_W'(ROOT_W - 1)) begin
        run  <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sobel_filter.sv
// 3x3 Sobel gradient magnitude over a 9-pixel streamed window.
// Define SOBEL_SQRT_EN for floor(sqrt(S)) output; otherwise S = Gx^2 + Gy^2 is output.
module sobel_filter
  import sobel_pkg::*;
#(
  parameter int unsigned PIX_W = sobel_pkg::PIX_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_rgb_vld,
  input  logic [PIX_W-1:0] i_rgb_data,
  output logic             i_rgb_busy,
  input  logic             o_result_busy,
  output logic             o_result_vld,
  output logic [PIX_W-1:0] o_result_data
);

  state_t                   state;
  logic [CNT_W-1:0]         count;
  logic signed [ACC_W-1:0]  acc_x;
  logic signed [ACC_W-1:0]  acc_y;
  logic [7:0]               gray;
  logic signed [ACC_W-1:0]  gray_s;
  logic signed [2*ACC_W-1:0] sq_x;
  logic signed [2*ACC_W-1:0] sq_y;
  logic [SUM_W-1:0]         mag_sq;
  logic                     xfer;

  assign i_rgb_busy = i_rst || (state != ST_ACCUM);
  assign xfer       = i_rgb_vld && !i_rgb_busy;

  always_comb begin
    gray   = gray_of(i_rgb_data[7:0], i_rgb_data[15:8], i_rgb_data[23:16]);
    gray_s = $signed({{(ACC_W-8){1'b0}}, gray});
    sq_x   = acc_x * acc_x;
    sq_y   = acc_y * acc_y;
    mag_sq = SUM_W'(sq_x) + SUM_W'(sq_y);
  end

`ifdef SOBEL_SQRT_EN
  logic [ROOT_W-1:0] root;
  logic              root_done;

  // Launched from CALC so the root starts on the same edge S is formed
  sobel_isqrt u_isqrt (
    .clk      (i_clk),
    .rst      (i_rst),
    .start    (state == ST_CALC),
    .radicand ({{(RAD_W-SUM_W){1'b0}}, mag_sq}),
    .root     (root),
    .done     (root_done)
  );
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= ST_ACCUM;
      count         <= '0;
      acc_x         <= '0;
      acc_y         <= '0;
      o_result_vld  <= 1'b0;
      o_result_data <= '0;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (xfer) begin
            acc_x <= acc_x + GX_MASK[count] * gray_s;
            acc_y <= acc_y + GY_MASK[count] * gray_s;
            if (count == CNT_W'(WIN - 1)) begin
              state <= ST_CALC;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        ST_CALC: begin
`ifdef SOBEL_SQRT_EN
          state <= ST_ROOT;
`else
          o_result_data <= PIX_W'(mag_sq);
          o_result_vld  <= 1'b1;
          state         <= ST_OUT;
`endif
        end
`ifdef SOBEL_SQRT_EN
        ST_ROOT: begin
          if (root_done) begin
            o_result_data <= PIX_W'(root);
            o_result_vld  <= 1'b1;
            state         <= ST_OUT;
          end
        end
`endif
        ST_OUT: begin
          if (!o_result_busy) begin
            o_result_vld <= 1'b0;
            count        <= '0;
            acc_x        <= '0;
            acc_y        <= '0;
            state        <= ST_ACCUM;
          end
        end
        default: state <= ST_ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_filter.sv
// Scoreboard bench for sobel_filter; expectations follow SOBEL_SQRT_EN when defined.
module tb_sobel_filter;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_rgb_vld = 1'b0;
  logic [23:0] i_rgb_data = '0;
  logic        i_rgb_busy;
  logic        o_result_busy = 1'b0;
  logic        o_result_vld;
  logic [23:0] o_result_data;

  int n_checks = 0;
  int n_fail   = 0;
  int n_push   = 0;
  int n_pop    = 0;
  int exp_q[$];
  logic rand_ready = 1'b0;
  logic [23:0] win [9];

`ifdef SOBEL_SQRT_EN
  localparam int EXP_EDGE = 1020;
  localparam int EXP_DIAG = 360;
`else
  localparam int EXP_EDGE = 1040400;
  localparam int EXP_DIAG = 130050;
`endif

  sobel_filter #(.PIX_W(24)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_rgb_vld     (i_rgb_vld),
    .i_rgb_data    (i_rgb_data),
    .i_rgb_busy    (i_rgb_busy),
    .o_result_busy (o_result_busy),
    .o_result_vld  (o_result_vld),
    .o_result_data (o_result_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per accepted result
  always @(negedge i_clk) begin
    if (!i_rst && o_result_vld && !o_result_busy) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got %0d expected none", o_result_data);
      end else begin
        chk("result", int'(o_result_data), exp_q.pop_front());
        n_pop++;
      end
    end
  end

  always @(posedge i_clk) begin
    #1;
    if (rand_ready) o_result_busy = ($urandom_range(0, 2) == 0);
  end

  function automatic int model();
    int cx [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    int cy [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
    int gx, gy, g, s, r;
    gx = 0;
    gy = 0;
    for (int i = 0; i < 9; i++) begin
      g  = (int'(win[i][7:0]) + int'(win[i][15:8]) + int'(win[i][23:16])) / 3;
      gx += cx[i] * g;
      gy += cy[i] * g;
    end
    s = gx * gx + gy * gy;
`ifdef SOBEL_SQRT_EN
    r = 0;
    while ((r + 1) * (r + 1) <= s) r++;
    return r;
`else
    r = s;
    return r;
`endif
  endfunction

  task automatic send(input logic [23:0] d, input int gap);
    int  n;
    logic ok;
    repeat (gap) begin
      i_rgb_vld  = 1'b0;
      i_rgb_data = 24'($urandom);
      @(posedge i_clk); #1;
    end
    i_rgb_vld  = 1'b1;
    i_rgb_data = d;
    n = 0;
    forever begin
      @(negedge i_clk);
      ok = !i_rgb_busy;
      @(posedge i_clk); #1;
      if (ok) break;
      n++;
      if (n > 64) begin
        chk("send_timeout", n, 0);
        break;
      end
    end
    i_rgb_vld  = 1'b0;
    i_rgb_data = 24'($urandom);
  endtask

  task automatic send_win(input int gap_max);
    for (int i = 0; i < 9; i++) send(win[i], $urandom_range(0, gap_max));
  endtask

  task automatic wait_vld(output int lat);
    lat = 0;
    while (!o_result_vld && lat < 40) begin
      @(posedge i_clk); #1;
      lat++;
    end
  endtask

  task automatic set_rows(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c);
    for (int r = 0; r < 3; r++) begin
      win[3*r] = a; win[3*r+1] = b; win[3*r+2] = c;
    end
  endtask

  task automatic do_reset(input int cycles);
    i_rst = 1'b1;
    repeat (cycles) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_vld", int'(o_result_vld), 0);
    chk("rst_data", int'(o_result_data), 0);
    chk("rst_busy", int'(i_rgb_busy), 1);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("post_rst_busy", int'(i_rgb_busy), 0);
    @(posedge i_clk); #1;
  endtask

  initial begin
    int lat;
    do_reset(2);

    // Flat gray field
    for (int i = 0; i < 9; i++) win[i] = 24'h808080;
    exp_q.push_back(0); n_push++;
    send_win(0);
    wait_vld(lat);
    chk("latency_flat_le16", int'(lat <= 16), 1);
    repeat (3) @(posedge i_clk); #1;

    // Vertical edge on the right column
    set_rows(24'h000000, 24'h000000, 24'hFFFFFF);
    exp_q.push_back(EXP_EDGE); n_push++;
    send_win(1);
    wait_vld(lat);
    chk("latency_edge_le16", int'(lat <= 16), 1);
    repeat (3) @(posedge i_clk); #1;

    // Single bright corner, others gray 0
    for (int i = 0; i < 8; i++) win[i] = 24'h000001;
    win[8] = 24'hFFFFFF;
    exp_q.push_back(EXP_DIAG); n_push++;
    send_win(0);
    wait_vld(lat);
    repeat (3) @(posedge i_clk); #1;

    // Horizontal edge with downstream stall and input pressure
    set_rows(24'h000000, 24'h000000, 24'h000000);
    win[0] = 24'hFFFFFF; win[1] = 24'hFFFFFF; win[2] = 24'hFFFFFF;
    exp_q.push_back(EXP_EDGE); n_push++;
    o_result_busy = 1'b1;
    send_win(0);
    wait_vld(lat);
    chk("hold_vld_seen", int'(o_result_vld), 1);
    for (int k = 0; k < 5; k++) begin
      i_rgb_vld  = 1'b1;
      i_rgb_data = 24'($urandom);
      @(negedge i_clk);
      chk("hold_vld", int'(o_result_vld), 1);
      chk("hold_data", int'(o_result_data), EXP_EDGE);
      chk("hold_in_busy", int'(i_rgb_busy), 1);
      @(posedge i_clk); #1;
    end
    i_rgb_vld     = 1'b0;
    o_result_busy = 1'b0;
    repeat (3) @(posedge i_clk); #1;

    // Reset while a result is held in OUT drops it
    o_result_busy = 1'b1;
    send_win(0);
    wait_vld(lat);
    do_reset(1);
    o_result_busy = 1'b0;

    // Partial window discarded by reset
    for (int i = 0; i < 4; i++) send(24'hFFFFFF, 0);
    do_reset(1);
    set_rows(24'h000000, 24'h000000, 24'hFFFFFF);
    exp_q.push_back(EXP_EDGE); n_push++;
    send_win(0);
    wait_vld(lat);
    repeat (3) @(posedge i_clk); #1;

    // Back-to-back random windows with gapped input and random stalls
    rand_ready = 1'b1;
    for (int w = 0; w < 6; w++) begin
      for (int i = 0; i < 9; i++) win[i] = 24'($urandom);
      exp_q.push_back(model()); n_push++;
      send_win(2);
    end
    lat = 0;
    while (exp_q.size() != 0 && lat < 400) begin
      @(posedge i_clk); #1;
      lat++;
    end
    rand_ready    = 1'b0;
    o_result_busy = 1'b0;
    repeat (20) @(posedge i_clk); #1;
    chk("results_outstanding", exp_q.size(), 0);
    chk("result_count", n_pop, n_push);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1);
  end

endmodule
